// File: rtl/crank_cam_gen_if.sv
// Crank/cam generator bus: run control and period in, waveform and status out.
interface crank_cam_gen_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic                    ena;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    cap;
  logic                    cam;
  logic [5:0]              tooth_idx;
  logic                    rev;
  logic                    slot_start;
  logic                    busy;

  modport master (
    output ena, period,
    input  cap, cam, tooth_idx, rev, slot_start, busy
  );

  modport slave (
    input  ena, period,
    output cap, cam, tooth_idx, rev, slot_start, busy
  );
endinterface

// File: rtl/crank_cam_gen.sv
// Synthetic 60-2 crank wheel and cam sensor generator with programmable
// tooth period. All outputs are registered from next-state values.
module crank_cam_gen #(
  parameter int PERIOD_WIDTH = 24,
  parameter int TEETH        = 60,
  parameter int GAP          = 2,
  parameter int CAM_RISE     = 10,
  parameter int CAM_FALL     = 40
) (
  input  logic            clk,
  input  logic            rst,
  crank_cam_gen_if.slave  bus
);

  localparam logic [5:0] LAST_SLOT = 6'(TEETH - 1);
  localparam logic [5:0] GAP_START = 6'(TEETH - GAP);
  localparam logic [7:0] REV_OFS   = 8'(TEETH);
  localparam logic [7:0] RISE      = 8'(CAM_RISE);
  localparam logic [7:0] FALL      = 8'(CAM_FALL);
  localparam bit         WRAP      = (CAM_RISE >= CAM_FALL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_n;
  logic [PERIOD_WIDTH-1:0] cnt, cnt_n;
  logic [PERIOD_WIDTH-1:0] p_lat, p_lat_n;
  logic [PERIOD_WIDTH-1:0] p_eff;
  logic [5:0]              tooth, tooth_n;
  logic                    rev, rev_n;
  logic                    start_n;
  logic [7:0]              pos_n;
  logic                    busy_n, cap_n, cam_n;
  logic                    cap_q, cam_q, start_q, busy_q;

  // Clamp requested period to a minimum of two cycles.
  always_comb begin
    p_eff = (bus.period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : bus.period;
  end

  // Next-state and next-output logic; outputs derive from next state so the
  // registered copies line up with the slot counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_lat_n = p_lat;
    tooth_n = tooth;
    rev_n   = rev;
    start_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ena) begin
          state_n = RUN;
          cnt_n   = '0;
          tooth_n = '0;
          rev_n   = 1'b0;
          p_lat_n = p_eff;
          start_n = 1'b1;
        end
      end
      RUN: begin
        if (cnt == p_lat - PERIOD_WIDTH'(1)) begin
          if (!bus.ena) begin
            state_n = IDLE;
          end else begin
            cnt_n   = '0;
            p_lat_n = p_eff;
            start_n = 1'b1;
            if (tooth == LAST_SLOT) begin
              tooth_n = '0;
              rev_n   = ~rev;
            end else begin
              tooth_n = tooth + 6'd1;
            end
          end
        end else begin
          cnt_n = cnt + PERIOD_WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    pos_n  = rev_n ? (REV_OFS + {2'b00, tooth_n}) : {2'b00, tooth_n};
    cap_n  = busy_n && (tooth_n < GAP_START) && (cnt_n < (p_lat_n >> 1));
    if (WRAP) begin
      cam_n = busy_n && ((pos_n >= RISE) || (pos_n < FALL));
    end else begin
      cam_n = busy_n && (pos_n >= RISE) && (pos_n < FALL);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p_lat   <= '0;
      tooth   <= '0;
      rev     <= 1'b0;
      cap_q   <= 1'b0;
      cam_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      p_lat   <= p_lat_n;
      tooth   <= tooth_n;
      rev     <= rev_n;
      cap_q   <= cap_n;
      cam_q   <= cam_n;
      start_q <= start_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.cap        = cap_q;
  assign bus.cam        = cam_q;
  assign bus.tooth_idx  = tooth;
  assign bus.rev        = rev;
  assign bus.slot_start = start_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Bench for crank_cam_gen: expected slot descriptors are queued by the
// stimulus and checked by an independent monitor on each slot_start.
module tb_crank_cam_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crank_cam_gen_if #(.PERIOD_WIDTH(24)) bus ();

  crank_cam_gen #(
    .PERIOD_WIDTH(24),
    .TEETH(60),
    .GAP(2),
    .CAM_RISE(10),
    .CAM_FALL(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int tooth;
    int rev;
    int cam;
    int p;
    int high;
    bit chk;
  } slot_t;

  slot_t q[$];
  slot_t cur;
  bit    in_slot = 1'b0;
  int    len = 0;
  int    hi = 0;
  int    slot_cnt = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected slot k of a run with effective period p (60-2 wheel, cam 10..39).
  function automatic void push_slot(input int k, input int p, input bit c);
    slot_t s;
    int pos;
    s.tooth = k % 60;
    s.rev   = (k / 60) % 2;
    pos     = s.rev * 60 + s.tooth;
    s.cam   = (pos >= 10 && pos < 40) ? 1 : 0;
    s.p     = p;
    s.high  = (s.tooth < 58) ? p / 2 : 0;
    s.chk   = c;
    q.push_back(s);
  endfunction

  // Monitor: closes a slot on the next slot_start or on busy dropping.
  always @(negedge clk) begin
    if (in_slot && (bus.slot_start || !bus.busy)) begin
      if (cur.chk) begin
        chk("slot_len", len, cur.p);
        chk("slot_high", hi, cur.high);
      end
      in_slot = 1'b0;
    end
    if (!bus.busy) begin
      if (rst === 1'b0) begin
        chk("idle_cap", int'(bus.cap), 0);
        chk("idle_cam", int'(bus.cam), 0);
        chk("idle_start", int'(bus.slot_start), 0);
      end
    end else if (bus.slot_start) begin
      slot_cnt++;
      chk("slot_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("tooth_idx", int'(bus.tooth_idx), cur.tooth);
        chk("rev", int'(bus.rev), cur.rev);
        chk("cam_at_start", int'(bus.cam), cur.cam);
        in_slot = 1'b1;
        len = 0;
        hi = 0;
      end
    end
    if (in_slot) begin
      len++;
      if (bus.cap) hi++;
      chk("cam_stable", int'(bus.cam), cur.cam);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_slots(input int target);
    for (int i = 0; i < 2000 && slot_cnt < target; i++) step(1);
    if (slot_cnt < target) chk("wait_slot_timeout", slot_cnt, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && bus.busy; i++) step(1);
    if (bus.busy) chk("wait_idle_timeout", int'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.period = 24'd10;
    step(3);
    chk("rst_cap", int'(bus.cap), 0);
    chk("rst_cam", int'(bus.cam), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tooth", int'(bus.tooth_idx), 0);
    chk("rst_rev", int'(bus.rev), 0);
    chk("rst_start", int'(bus.slot_start), 0);
    rst = 1'b0;
    step(2);

    // Period 10 across the gap and into rev 1, ena dropped at cycle 3.
    for (int k = 0; k < 62; k++) push_slot(k, 10, 1'b1);
    base = slot_cnt;
    bus.ena = 1'b1;
    step(1);
    chk("first_slot_busy", int'(bus.busy), 1);
    chk("first_slot_cap", int'(bus.cap), 1);
    chk("first_slot_count", slot_cnt, base + 1);
    wait_slots(base + 62);
    step(3);
    bus.ena = 1'b0;
    wait_idle();
    chk("idle_hold_tooth", int'(bus.tooth_idx), 1);
    chk("idle_hold_rev", int'(bus.rev), 1);
    step(3);

    // Period 4 over one full cam cycle plus one slot.
    bus.period = 24'd4;
    for (int k = 0; k < 121; k++) push_slot(k, 4, 1'b1);
    base = slot_cnt;
    bus.ena = 1'b1;
    wait_slots(base + 121);
    step(1);
    bus.ena = 1'b0;
    wait_idle();
    step(2);

    // Period 7, clamps of 1 and 0, then 10 changed to 20 mid-slot.
    bus.period = 24'd7;
    push_slot(0, 7, 1'b1);
    push_slot(1, 2, 1'b1);
    push_slot(2, 2, 1'b1);
    push_slot(3, 10, 1'b1);
    push_slot(4, 20, 1'b1);
    base = slot_cnt;
    bus.ena = 1'b1;
    wait_slots(base + 1);
    bus.period = 24'd1;
    wait_slots(base + 2);
    bus.period = 24'd0;
    wait_slots(base + 3);
    bus.period = 24'd10;
    wait_slots(base + 4);
    step(3);
    bus.period = 24'd20;
    wait_slots(base + 5);
    step(3);
    bus.ena = 1'b0;
    wait_idle();
    step(2);

    // Reset mid-slot while cap is high, ena held, then restart.
    bus.period = 24'd10;
    push_slot(0, 10, 1'b1);
    push_slot(1, 10, 1'b1);
    push_slot(2, 10, 1'b0);
    base = slot_cnt;
    bus.ena = 1'b1;
    wait_slots(base + 3);
    step(1);
    chk("pre_rst_cap", int'(bus.cap), 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_cap", int'(bus.cap), 0);
    chk("mid_rst_cam", int'(bus.cam), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_tooth", int'(bus.tooth_idx), 0);
    step(1);
    push_slot(0, 10, 1'b1);
    push_slot(1, 10, 1'b1);
    base = slot_cnt;
    rst = 1'b0;
    step(1);
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_start", int'(bus.slot_start), 1);
    chk("restart_count", slot_cnt, base + 1);
    wait_slots(base + 2);
    step(3);
    bus.ena = 1'b0;
    wait_idle();
    step(2);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crank_cam_gen.md
Name: crank_cam_gen

Overview:
- Synthetic crank (60-2 toothed wheel) and cam sensor signal generator; the transmit-side counterpart of the angle-generator core's crank/cam capture.
- Drives cap/cam waveforms with a programmable tooth period.
- Used as on-chip stimulus for bench and hardware-in-loop testing of angle sync, gap detection and cam phase logic.
- Output cap is a clean digital signal (no bounce); the downstream filter sees ideal edges.

Parameters:
- PERIOD_WIDTH, 24, width of tooth-period input in clk cycles
- TEETH, 60, tooth slots per crank revolution (incl. missing)
- GAP, 2, missing teeth at end of revolution (slots TEETH-GAP..TEETH-1)
- CAM_RISE, 10, cam goes high at this slot index within the 2-rev cycle (0..2*TEETH-1)
- CAM_FALL, 40, cam goes low at this slot index within the 2-rev cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ena  in  1  run request, level
- period  in  PERIOD_WIDTH  tooth slot length in clk cycles
- cap  out  1  crank signal
- cam  out  1  cam signal
- tooth_idx  out  6  current slot index 0..TEETH-1
- rev  out  1  revolution within cam cycle (0/1)
- slot_start  out  1  one-cycle pulse on first clock of each slot
- busy  out  1  state==RUN

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high.
- Reset: all outputs and state 0, state IDLE; rst has priority over everything incl. ena, mid-slot.
- States IDLE, RUN.
- IDLE->RUN when ena=1 sampled at edge N. At N+1: slot 0 begins, tooth_idx=0, rev=0, slot_start=1.
- period is latched as P_lat only on the clock a slot begins; changes mid-slot are ignored until the next slot_start.
  - P_eff = max(period,2); 0 and 1 are clamped to 2.
- Slot timing: cycle counter runs 0..P_eff-1 within a slot.
  - Present tooth (tooth_idx < TEETH-GAP): cap=1 for cycles 0..floor(P_eff/2)-1, cap=0 for the rest.
  - Missing slots: cap=0 for the entire slot.
  - Falling edge of each present tooth is at cycle floor(P_eff/2).
- Slot end (counter==P_eff-1):
  - tooth_idx increments.
  - At TEETH-1 it wraps to 0 and rev toggles.
  - 2-rev cycle position pos = rev*TEETH + tooth_idx.
- cam = 1 iff CAM_RISE <= pos < CAM_FALL.
  - Registered, updates with slot_start; constant within a slot.
  - If CAM_RISE >= CAM_FALL the interval wraps: cam=1 iff pos>=CAM_RISE or pos<CAM_FALL.
- ena=0 during RUN: current slot completes; at the slot end, state goes to IDLE instead of starting the next slot.
  - In IDLE: cap=0, cam=0, slot_start=0, busy=0; tooth_idx/rev hold their last values.
  - A restart resets them to 0.
- ena re-asserted before the slot end: no effect, run continues seamlessly.
- No combinational paths from inputs to outputs; all outputs registered.
- Width rules:
  - Half-period is a right shift of P_eff.
  - Cycle counter is PERIOD_WIDTH bits; no overflow possible since counter < P_eff.

Test Plan:
- rst, period=10, ena=1 -> one cycle after ena, cap=1 for 5 clk then 0 for 5 clk.
  - 58 falling edges per revolution; spacing between consecutive falling edges is 10 clk, and 30 clk across the gap.
  - slot_start every 10 clk; rev toggles every 600 clk.
- period=7 -> high 3 clk, low 4 clk.
- period=1 and period=0 -> clamped to 2: high 1, low 1.
- Change period from 10 to 20 mid-slot -> current slot stays 10 clk; the next slot_start begins a 20-clk slot.
- Cam, period=4 -> cam rises at start of slot pos 10 (clk 40 after run start) and falls at start of pos 40 (clk 160).
  - Pattern repeats every 480 clk; cam=0 throughout rev=1.
- ena dropped at cycle 3 of a 10-clk slot -> slot finishes (cap low at cycle 5), busy=0 exactly at the slot end.
  - Re-enable restarts with tooth_idx=0, rev=0.
- rst asserted mid-slot with cap=1 -> next clk: cap=0, cam=0, busy=0, tooth_idx=0; ena held high -> restart one clk after rst deasserts.
